// File: rtl/onehot_rr_arbiter.sv
// Round-robin arbiter: one-hot grant plus valid/ready handshake toward one shared resource.
// Latency: combinational req_i -> gnt_o/valid_o, same cycle; pointer and lock update on clk_i rise.
// Backpressure: ready_i low holds an issued grant stable (LOCK_IN=1) until accepted or the request drops.
module onehot_rr_arbiter #(
  parameter int NUM_REQ   = 16,
  parameter int LOCK_IN   = 1,
  parameter int PTR_WIDTH = (NUM_REQ == 1) ? 1 : $clog2(NUM_REQ)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 flush_i,
  input  logic [NUM_REQ-1:0]   req_i,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [NUM_REQ-1:0]   gnt_o,
  output logic [PTR_WIDTH-1:0] ptr_o
);

  // Lock FSM encoding: the state register is the lock flag itself.
  localparam logic ST_IDLE   = 1'b0;
  localparam logic ST_LOCKED = 1'b1;

  // State
  logic [PTR_WIDTH-1:0] r_ptr;   // highest-priority index for the next fresh arbitration
  logic                 r_lock;  // FSM state, ST_LOCKED while a grant waits for ready_i
  logic [NUM_REQ-1:0]   r_gnt;   // grant captured when the lock was taken

  // Combinational nets
  logic [NUM_REQ-1:0]   w_mask;        // bits at or above r_ptr
  logic [NUM_REQ-1:0]   w_req_masked;  // requests in the first half of the circular scan
  logic [NUM_REQ-1:0]   w_gnt_arb;     // fresh round-robin winner
  logic                 w_lock_hold;   // locked requester is still asking
  logic [NUM_REQ-1:0]   w_gnt;         // grant actually presented
  logic                 w_vld;
  logic                 w_hs;          // handshake this cycle
  logic [PTR_WIDTH-1:0] w_gnt_idx;     // binary index of w_gnt
  logic [PTR_WIDTH-1:0] w_ptr_nxt;     // index after the winner, wrapping to 0
  logic                 w_take_lock;
  logic                 w_drop;        // locked requester withdrew without a handshake

  // Lowest set bit of a vector; the result is one-hot or zero by construction.
  function automatic logic [NUM_REQ-1:0] f_lowest(input logic [NUM_REQ-1:0] v);
    logic found;
    f_lowest = '0;
    found    = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && v[i]) begin
        f_lowest[i] = 1'b1;
        found       = 1'b1;
      end
    end
  endfunction

  // Thermometer mask selecting indices r_ptr .. NUM_REQ-1.
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_mask[i] = (PTR_WIDTH'(i) >= r_ptr);
    end
  end

  // Circular scan from r_ptr: prefer requests at or above the pointer, else wrap to the lowest one.
  always_comb begin
    w_req_masked = req_i & w_mask;
    if (|w_req_masked) begin
      w_gnt_arb = f_lowest(w_req_masked);
    end else begin
      w_gnt_arb = f_lowest(req_i);
    end
  end

  // Select the presented grant: reset masks it, a lock holds it, a withdrawn lock blanks it.
  always_comb begin
    w_lock_hold = |(req_i & r_gnt);
    w_gnt       = '0;
    if (rst_i) begin
      w_gnt = '0;
    end else if (r_lock == ST_LOCKED) begin
      w_gnt = w_lock_hold ? r_gnt : '0;
    end else begin
      w_gnt = w_gnt_arb;
    end
  end

  // One-hot to binary for the winner index; OR-reduction is exact because w_gnt is one-hot or zero.
  always_comb begin
    w_gnt_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_gnt[i]) begin
        w_gnt_idx = w_gnt_idx | PTR_WIDTH'(i);
      end
    end
  end

  // Next pointer after a handshake, plus FSM transition qualifiers.
  always_comb begin
    w_vld       = |w_gnt;
    w_hs        = w_vld && ready_i;
    w_ptr_nxt   = (w_gnt_idx == PTR_WIDTH'(NUM_REQ - 1)) ? '0 : (w_gnt_idx + 1'b1);
    w_take_lock = (LOCK_IN == 1) && (r_lock == ST_IDLE) && w_vld && !ready_i;
    w_drop      = (r_lock == ST_LOCKED) && !w_lock_hold;
  end

  // Pointer, lock and held-grant update; reset and flush win over a simultaneous handshake.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      r_ptr  <= '0;
      r_lock <= ST_IDLE;
      r_gnt  <= '0;
    end else if (w_hs) begin
      r_ptr  <= w_ptr_nxt;
      r_lock <= ST_IDLE;
    end else if (w_drop) begin
      // Pointer deliberately left alone: the dropped requester never got service.
      r_lock <= ST_IDLE;
    end else if (w_take_lock) begin
      r_lock <= ST_LOCKED;
      r_gnt  <= w_gnt;
    end
  end

  assign gnt_o   = w_gnt;
  assign valid_o = w_vld;
  assign ptr_o   = r_ptr;

  // Grant must never be multi-hot; the downstream encoder depends on it.
  a_onehot : assert property (@(posedge clk_i) $onehot0(gnt_o));

  // valid_o is exactly the reduction of the grant.
  a_valid : assert property (@(posedge clk_i) valid_o == (|gnt_o));

  // A locked requester must keep requesting until it is accepted.
  a_lock_drop : assert property (@(posedge clk_i) disable iff (rst_i || flush_i)
                                 !((r_lock == ST_LOCKED) && !w_lock_hold))
    else $warning("onehot_rr_arbiter: locked requester withdrew its request before ready_i");

endmodule

// File: doc/onehot_rr_arbiter.md
Name: onehot_rr_arbiter

Overview:
- Round-robin arbiter producing a one-hot grant vector plus valid/ready handshake toward a single shared resource.
- Sits directly upstream of the one-hot-to-binary encoder: gnt_o feeds the encoder's onehot input, whose binary output selects the winning requester's payload in the consumer mux.
- Guarantees gnt_o is one-hot or all-zero every cycle, so the downstream encoder never sees a multi-hot vector.

Parameters:
- NUM_REQ, 16, number of requesters; legal range 1..256.
- LOCK_IN, 1, when 1 a granted-but-unaccepted grant is held stable until ready_i; when 0 the grant may change every cycle.
- PTR_WIDTH, NUM_REQ==1 ? 1 : $clog2(NUM_REQ), derived, do not override.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_i  input  1  synchronous active-high reset.
- flush_i  input  1  synchronous clear of lock and priority pointer; behaves as reset.
- req_i  input  NUM_REQ  request vector; bit i = requester i pending.
- valid_o  output  1  a grant is presented; equals |gnt_o.
- ready_i  input  1  consumer accepts the current grant this cycle.
- gnt_o  output  NUM_REQ  one-hot grant vector, or all-zero when valid_o=0.
- ptr_o  output  PTR_WIDTH  current priority pointer (highest-priority index), for debug and verification.

Behaviour:
- Interface: one clock clk_i; reset rst_i is synchronous and active-high.
- State: ptr_q (PTR_WIDTH bits), lock_q (1 bit), gnt_q (NUM_REQ bits, the held grant).
- Reset (rst_i=1 at a clock edge): ptr_q=0, lock_q=0, gnt_q=0.
- While rst_i is high, gnt_o and valid_o are forced to 0, and ptr_o reads 0 after the first reset edge.
- Arbitration is combinational with zero latency, req_i to gnt_o in the same cycle.
  - Unlocked: grant the first set bit of req_i scanning indices ptr_q, ptr_q+1, ..., NUM_REQ-1, 0, ..., ptr_q-1.
  - req_i=0 gives gnt_o=0 and valid_o=0.
- Handshake occurs when valid_o=1 and ready_i=1 at a clock edge. For a handshake on index k:
  - ptr_q <= (k+1) mod NUM_REQ; wraps NUM_REQ-1 to 0.
  - lock_q <= 0.
- FSM, two states:
  - IDLE (lock_q=0): on valid_o=1 and ready_i=0 with LOCK_IN=1, go to LOCKED and capture gnt_q<=gnt_o. Otherwise stay in IDLE.
  - LOCKED (lock_q=1): gnt_o=gnt_q regardless of new higher-priority requests; ptr_q is unchanged.
    - Handshake: go to IDLE and advance ptr_q as above.
    - Locked requester drops its request (req_i & gnt_q == 0): protocol violation. Go to IDLE next cycle with ptr_q unchanged; gnt_o is driven to 0 in that cycle. A simulation assertion flags it.
- LOCK_IN=0: lock_q stays 0 and the FSM is always IDLE.
- No request is ever starved: a continuously asserting requester is granted within NUM_REQ handshakes.
- flush_i=1: same effect as reset on state at the next edge. It overrides a simultaneous handshake; the pointer does not advance. Outputs are not masked during flush.
- rst_i asserted mid-LOCKED: the lock is dropped; after reset release, arbitration restarts from index 0.
- NUM_REQ=1: gnt_o=req_i, ptr_o is always 0, and the lock behaves as above.
- Invariant, assertion-checked: $onehot0(gnt_o), and valid_o == |gnt_o.

Test Plan (NUM_REQ=4, LOCK_IN=1 unless noted):
- Reset, then req_i=4'b1111 with ready_i=1 held for 5 cycles:
  - gnt_o sequence 0001, 0010, 0100, 1000, 0001.
  - ptr_o sequence 0, 1, 2, 3, 0 (wrap).
- ptr_o=2, req_i=4'b0011, ready_i=1:
  - gnt_o=0001 (wrap scan), then ptr_o=1.
  - Next cycle gnt_o=0010.
- req_i=4'b0100, ready_i=0 for 3 cycles, with req_i=4'b0101 from cycle 2 and ptr_o=2:
  - gnt_o stays 0100 for all 3 cycles (locked).
  - ready_i=1 in cycle 4 gives a handshake, ptr_o=3, and the next gnt_o is 0001.
- Locked on 0100, then req_i drops to 0 with ready_i=0:
  - Assertion fires; gnt_o=0000 that cycle.
  - Next cycle the FSM is IDLE and ptr_o is unchanged.
- During a handshake on index 1, assert flush_i (and, in a separate run, rst_i):
  - Next cycle ptr_o=0 and lock_q=0.
  - With reset, gnt_o=0 while rst_i is high.
- LOCK_IN=0, req_i=4'b0010 with ready_i=0, then req_i=4'b0011 with ptr_o=0:
  - gnt_o moves 0010 to 0001 immediately (no hold).
- Every cycle of random stimulus: gnt_o is one-hot or zero, and every pending requester is granted within 4 handshakes.
